// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux_sched 1-to-4 stream scheduler.
package stream_demux_pkg;

    localparam int unsigned N_OUT = 4;

    localparam logic RR_MODE  = 1'b0;
    localparam logic SEL_MODE = 1'b1;

    typedef enum logic {IDLE, HOLD} sched_state_t;

    typedef logic [1:0] dest_t;

    // One-hot lane vector for a destination index.
    function automatic logic [N_OUT-1:0] dest_onehot(input dest_t d);
        return N_OUT'(1) << d;
    endfunction

endpackage

// File: rtl/stream_demux_sched_rr_pick4.sv
// Combinational round-robin picker: first enabled lane at or after rr_ptr_i, wrapping 3->0.
module rr_pick4
    import stream_demux_pkg::*;
(
    input  logic [N_OUT-1:0] en_mask_i,
    input  dest_t            rr_ptr_i,
    output dest_t            tgt_o,
    output logic             tgt_ok_o
);

    dest_t idx;
    logic  found;

    always_comb begin
        tgt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < int'(N_OUT); i++) begin
            idx = rr_ptr_i + 2'(i);
            if (!found && en_mask_i[idx]) begin
                tgt_o = idx;
                found = 1'b1;
            end
        end
    end

    assign tgt_ok_o = |en_mask_i;

endmodule

// File: rtl/stream_demux_sched.sv
// Valid/ready 1-to-4 demux scheduler with a single holding register.
// Optional saturating statistics counters are built when DEMUX_SCHED_STATS_EN is defined.
module stream_demux_sched
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode,
    input  logic [1:0]        in_sel,
    input  logic [N_OUT-1:0]  en_mask,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        cur_dest,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    sched_state_t      state_q;
    dest_t             cur_dest_q;
    dest_t             rr_ptr_q;
    logic [DATA_W-1:0] data_q;
    logic [N_OUT-1:0]  out_valid_q;

    dest_t rr_tgt;
    dest_t tgt;
    logic  rr_ok;
    logic  tgt_ok;
    logic  out_fire;
    logic  acc;
    logic  deliver;

    rr_pick4 u_pick (
        .en_mask_i (en_mask),
        .rr_ptr_i  (rr_ptr_q),
        .tgt_o     (rr_tgt),
        .tgt_ok_o  (rr_ok)
    );

    assign out_fire = (state_q == HOLD) && out_ready[cur_dest_q];
    assign tgt      = (mode == SEL_MODE) ? dest_t'(in_sel) : rr_tgt;
    assign tgt_ok   = (mode == SEL_MODE) ? 1'b1 : rr_ok;
    assign in_ready = ((state_q == IDLE) || out_fire) && tgt_ok;
    assign acc      = in_valid && in_ready;
    // A selected-but-disabled lane accepts the beat and discards it.
    assign deliver  = acc && en_mask[tgt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_dest_q  <= '0;
            rr_ptr_q    <= '0;
            data_q      <= '0;
            out_valid_q <= '0;
        end else begin
            if (acc && (mode == RR_MODE)) begin
                rr_ptr_q <= tgt + 2'd1;
            end
            case (state_q)
                IDLE: begin
                    if (deliver) begin
                        state_q     <= HOLD;
                        data_q      <= in_data;
                        cur_dest_q  <= tgt;
                        out_valid_q <= dest_onehot(tgt);
                    end
                end
                HOLD: begin
                    // Acceptance in HOLD implies out_fire, so a reload replaces the departing beat.
                    if (deliver) begin
                        data_q      <= in_data;
                        cur_dest_q  <= tgt;
                        out_valid_q <= dest_onehot(tgt);
                    end else if (out_fire) begin
                        state_q     <= IDLE;
                        out_valid_q <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= '0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign cur_dest  = cur_dest_q;

`ifdef DEMUX_SCHED_STATS_EN
    logic [CNT_W-1:0] sent_q;
    logic [CNT_W-1:0] drop_q;
    logic             discard;

    assign discard = acc && !en_mask[tgt];

    // Saturating delivery and discard counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            if (out_fire && (sent_q != '1)) begin
                sent_q <= sent_q + CNT_W'(1);
            end
            if (discard && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign sent_cnt = sent_q;
    assign drop_cnt = drop_q;
`else
    assign sent_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux_sched.sv
// Directed scoreboard bench for stream_demux_sched.
module tb_stream_demux_sched;

`ifdef DEMUX_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       mode;
    logic [1:0] in_sel;
    logic [3:0] en_mask;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [1:0] cur_dest;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;
    int exp_sent = 0;
    int exp_drop = 0;
    int last_wait = 0;
    bit started = 1'b0;
    logic [9:0] sb[$];
    logic [9:0] item;

    stream_demux_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .in_sel    (in_sel),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_dest  (cur_dest),
        .sent_cnt  (sent_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: a lane whose valid and ready are both high fires on the next edge.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("onehot0", 32'($onehot0(out_valid)), 32'd1);
            if (|(out_valid & out_ready)) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    item = sb.pop_front();
                    chk("fire_dest", 32'(cur_dest), 32'(item[9:8]));
                    chk("fire_valid", 32'(out_valid), 32'(4'b0001 << item[9:8]));
                    chk("fire_data", 32'(out_data), 32'(item[7:0]));
                    exp_sent++;
                end
            end
        end
    end

    // Offer one beat, wait (bounded) for acceptance, then check the 1-cycle latency.
    task automatic send(input logic [7:0] d, input logic m, input logic [1:0] s,
                        input logic [1:0] ed, input bit drop);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        in_sel   = s;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        chk("accept", 32'(in_ready), 32'd1);
        if (drop) exp_drop++;
        else sb.push_back({ed, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (drop) begin
            chk("drop_no_valid", 32'(out_valid), 32'd0);
        end else begin
            chk("lat_valid", 32'(out_valid), 32'(4'b0001 << ed));
            chk("lat_data", 32'(out_data), 32'(d));
            chk("lat_dest", 32'(cur_dest), 32'(ed));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; in_sel = '0;
        en_mask = 4'b1111; out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_dest", 32'(cur_dest), 32'd0);
        chk("rst_sent", 32'(sent_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Round-robin over all lanes, back to back.
        for (int i = 0; i < 5; i++) begin
            send(8'h11 + 8'(i), 1'b0, 2'd0, 2'(i), 1'b0);
            chk("rr_nobubble", 32'(last_wait), 32'd0);
        end
        drain();

        // Masked round-robin (pointer now at 1).
        en_mask = 4'b1010;
        send(8'h21, 1'b0, 2'd0, 2'd1, 1'b0);
        send(8'h22, 1'b0, 2'd0, 2'd3, 1'b0);
        send(8'h23, 1'b0, 2'd0, 2'd1, 1'b0);
        send(8'h24, 1'b0, 2'd0, 2'd3, 1'b0);
        drain();
        en_mask = 4'b0000;
        in_valid = 1'b1;
        in_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mask0_ready", 32'(in_ready), 32'd0);
            chk("mask0_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Explicit select: disabled lane drops, enabled lane delivers.
        en_mask = 4'b1011;
        send(8'hAA, 1'b1, 2'd2, 2'd2, 1'b1);
        chk("drop_cnt1", 32'(drop_cnt), STATS ? 32'(exp_drop) : 32'd0);
        send(8'hBB, 1'b1, 2'd3, 2'd3, 1'b0);
        drain();

        // Back-pressure with foreign ready bits asserted (pointer still 0).
        en_mask = 4'b1111;
        out_ready = 4'b0000;
        send(8'h5C, 1'b0, 2'd0, 2'd0, 1'b0);
        out_ready = 4'b1110;
        in_valid = 1'b1;
        in_data = 8'h5D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h5C);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        send(8'h5D, 1'b0, 2'd0, 2'd1, 1'b0);
        chk("bp_reload_wait", 32'(last_wait), 32'd0);
        drain();

        // Mask drop on the held lane does not revoke the beat (pointer at 2).
        out_ready = 4'b0000;
        send(8'h66, 1'b0, 2'd0, 2'd2, 1'b0);
        en_mask = 4'b1011;
        repeat (2) @(negedge clk);
        chk("mask_hold_valid", 32'(out_valid), 32'b0100);
        @(posedge clk);
        #1;
        out_ready = 4'b0100;
        drain();
        chk("sent_mid", 32'(sent_cnt), STATS ? 32'(exp_sent) : 32'd0);
        chk("drop_mid", 32'(drop_cnt), STATS ? 32'(exp_drop) : 32'd0);

        // Reset while holding discards the beat and rewinds the pointer.
        en_mask = 4'b1111;
        out_ready = 4'b1111;
        send(8'h70, 1'b0, 2'd0, 2'd3, 1'b0);
        drain();
        out_ready = 4'b0000;
        send(8'h77, 1'b0, 2'd0, 2'd0, 1'b0);
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sent = 0;
        exp_drop = 0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dest", 32'(cur_dest), 32'd0);
        chk("mid_rst_sent", 32'(sent_cnt), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        out_ready = 4'b1111;
        send(8'h88, 1'b0, 2'd0, 2'd0, 1'b0);
        drain();
        chk("final_sent", 32'(sent_cnt), STATS ? 32'(exp_sent) : 32'd0);
        chk("final_drop", 32'(drop_cnt), STATS ? 32'(exp_drop) : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
